screen_scan_gen: RTL and testbench
==================================

Name: screen_scan_gen

Overview:
Synthesisable pixel-coordinate sweep generator. It drives the x/y/color/program inputs of the board render wrappers (e.g. board_2x2_wrapper), replacing the fixed 1080x2160 sweep loop with hardware.
- Screen size, scan order and single/continuous mode are runtime-configurable.
- Flow control is valid/ready, so render pipelines can stall the sweep.
- Frame completion is reported through a done pulse and a frame counter.

Parameters:
X_W, 11, width of x coordinate and frame_width.
Y_W, 12, width of y coordinate and frame_height.
COLOR_W, 32, width of background colour word.
PROG_W, 6, width of program code.
RENDER_PROG, 0, program code emitted with every swept pixel.
FC_W, 16, width of frame counter.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  start request; sampled only in IDLE.
abort  in  1  synchronous abort of sweep in progress.
col_major  in  1  1: y fastest, then x. 0: x fastest, then y.
continuous  in  1  1: restart at (0,0) after last pixel, indefinitely.
frame_width  in  X_W  pixels per row (W); latched on start.
frame_height  in  Y_W  pixels per column (H); latched on start.
bg_color  in  COLOR_W  colour emitted with each pixel; latched on start.
x_out  out  X_W  current x coordinate.
y_out  out  Y_W  current y coordinate.
color_out  out  COLOR_W  latched bg_color.
program_out  out  PROG_W  RENDER_PROG while out_valid, else 0.
out_valid  out  1  current beat valid.
out_ready  in  1  downstream accepts beat.
last  out  1  current beat is final pixel of frame.
busy  out  1  high in SCAN.
done  out  1  one-cycle pulse after final pixel accepted (single mode).
frame_count  out  FC_W  completed frames since reset; wraps modulo 2^FC_W.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched configuration 0.
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN when start=1 and W!=0 and H!=0.
  - W, H, col_major, continuous and bg_color are latched on that edge.
  - The first beat (0,0) is presented with out_valid=1 on the next cycle (latency 1).
- Start with W=0 or H=0 is ignored: remains IDLE, no done.
- Start while in SCAN or DONE is ignored.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_ready=0, x_out, y_out, color_out, last and program_out are held stable.
  - out_valid never drops inside SCAN except on abort.
- Advance, col_major=1: y+1. At y=H-1, y wraps to 0 and x+1.
- Advance, col_major=0: x+1. At x=W-1, x wraps to 0 and y+1.
- last = 1 exactly when x_out=W-1 and y_out=H-1. 1x1 frame: first beat has last=1.
- On transfer with last=1:
  - frame_count increments.
  - continuous=1: the next beat is (0,0) with no bubble; stays in SCAN.
  - continuous=0: go to DONE, out_valid=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort=1 in SCAN:
  - Next cycle goes IDLE with out_valid=0.
  - No done pulse, frame_count unchanged.
  - abort has priority over a simultaneous final-beat transfer.
- Counter arithmetic is unsigned with no overflow beyond W-1/H-1. Coordinates must never exceed W-1/H-1.
- Reset asserted mid-sweep: immediate return to reset values. A subsequent start restarts at (0,0).

Decomposition:
- A shared package screen_pkg holds the state encoding, RENDER_PROG and the default X_W/Y_W/COLOR_W.
- One sub-module, scan_axis_counter, is natural: a mod-N counter with enable, clear and wrap flag, instantiated twice (inner and outer axis).
- col_major selects which instance is inner.

Test Plan:
1. W=1080, H=2160, col_major=1, continuous=0, out_ready=1, start pulse -> 2,332,800 beats, y fastest.
   - Beat 2160 is (1,0); final beat is (1079,2159) with last=1.
   - done pulses once, frame_count=1.
2. W=4, H=3, col_major=0, out_ready randomly toggled -> beats (0,0),(1,0),…,(3,2) with no drops or repeats; outputs stable during stalls.
3. W=2, H=2, continuous=1, out_ready=1 for 10 beats -> sequence wraps (1,1)->(0,0) with no bubble.
   - frame_count=2 after beat 8; no done.
4. W=0, H=5, start -> stays IDLE: out_valid=0, busy=0, no done.
5. W=8, H=8, abort asserted at beat 20 -> out_valid=0 next cycle, IDLE, no done, frame_count unchanged.
   - New start begins at (0,0).
6. rst_n deasserted mid-sweep -> all outputs 0 asynchronously. After release, start with W=1, H=1 -> a single beat (0,0) with last=1, then done.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared definitions for the screen scan generator.
//   scan_state_e : sweep FSM encoding (IDLE / SCAN / DONE)
//   SCR_*        : default widths and the program code attached to every pixel
package screen_pkg;

  localparam int SCR_X_W       = 11;
  localparam int SCR_Y_W       = 12;
  localparam int SCR_COLOR_W   = 32;
  localparam int SCR_PROG_W    = 6;
  localparam int SCR_RENDER_PROG = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/screen_scan_gen_if.sv
// Pixel beat channel between the scan generator and a render pipeline.
//   master : drives x/y/color/program/last/out_valid, samples out_ready
//   slave  : the render side
interface screen_scan_gen_if
  import screen_pkg::*;
#(
  parameter int X_W     = SCR_X_W,
  parameter int Y_W     = SCR_Y_W,
  parameter int COLOR_W = SCR_COLOR_W,
  parameter int PROG_W  = SCR_PROG_W
);
  logic [X_W-1:0]     x_out;
  logic [Y_W-1:0]     y_out;
  logic [COLOR_W-1:0] color_out;
  logic [PROG_W-1:0]  program_out;
  logic               out_valid;
  logic               out_ready;
  logic               last;

  modport master (
    output x_out, y_out, color_out, program_out, out_valid, last,
    input  out_ready
  );

  modport slave (
    input  x_out, y_out, color_out, program_out, out_valid, last,
    output out_ready
  );
endinterface

// File: rtl/scan_axis_counter.sv
// Mod-N axis counter used for both sweep axes.
//   clr_i  : synchronous clear to 0 (priority over en_i)
//   en_i   : advance; wraps to 0 when the count equals max_i
//   max_i  : N-1 for the axis
//   cnt_o  : current coordinate
//   wrap_o : count is at max_i (next advance wraps)
module scan_axis_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == max_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/screen_scan_gen.sv
// Pixel-coordinate sweep generator feeding board render wrappers.
//   clk, rst_n            : clock, async active-low reset
//   start, abort          : begin sweep (IDLE only) / cancel sweep (SCAN)
//   col_major, continuous : scan order and free-running mode (latched on start)
//   frame_width/height    : W x H frame size (latched on start)
//   bg_color              : colour sent with every beat (latched on start)
//   bus (master)          : x/y/color/program/last beats with valid/ready
//   busy, done            : in SCAN / one-cycle pulse after single frame ends
//   frame_count           : completed frames since reset (wrapping)
module screen_scan_gen
  import screen_pkg::*;
#(
  parameter int X_W         = SCR_X_W,
  parameter int Y_W         = SCR_Y_W,
  parameter int COLOR_W     = SCR_COLOR_W,
  parameter int PROG_W      = SCR_PROG_W,
  parameter int RENDER_PROG = SCR_RENDER_PROG,
  parameter int FC_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               col_major,
  input  logic               continuous,
  input  logic [X_W-1:0]     frame_width,
  input  logic [Y_W-1:0]     frame_height,
  input  logic [COLOR_W-1:0] bg_color,
  screen_scan_gen_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic [FC_W-1:0]    frame_count
);
  scan_state_e state_q, state_d;

  logic [X_W-1:0]     w_q;
  logic [Y_W-1:0]     h_q;
  logic               cm_q, cont_q;
  logic [COLOR_W-1:0] color_q;
  logic [FC_W-1:0]    fc_q;

  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           x_wrap, y_wrap;
  logic           out_valid;

  logic start_ok, in_scan, fire, last_beat, cnt_clr, x_en, y_en;

  assign in_scan   = (state_q == ST_SCAN);
  assign start_ok  = (state_q == ST_IDLE) && start &&
                     (frame_width != '0) && (frame_height != '0);
  // abort wins over a same-cycle transfer, so nothing advances on that edge
  assign fire      = in_scan && !abort && bus.out_ready;
  assign last_beat = in_scan && x_wrap && y_wrap;
  assign cnt_clr   = start_ok || (in_scan && abort);

  // Inner axis steps every beat; outer axis steps when the inner one wraps.
  // On the final pixel both wrap together, giving (0,0) for continuous mode.
  assign x_en = fire && (cm_q ? y_wrap : 1'b1);
  assign y_en = fire && (cm_q ? 1'b1 : x_wrap);

  scan_axis_counter #(.W(X_W)) u_x_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(x_en),
    .max_i(w_q - 1'b1), .cnt_o(x_cnt), .wrap_o(x_wrap)
  );

  scan_axis_counter #(.W(Y_W)) u_y_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(y_en),
    .max_i(h_q - 1'b1), .cnt_o(y_cnt), .wrap_o(y_wrap)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_SCAN;
      ST_SCAN: begin
        if (abort)                              state_d = ST_IDLE;
        else if (fire && last_beat && !cont_q)  state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Configuration latch and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      h_q     <= '0;
      cm_q    <= 1'b0;
      cont_q  <= 1'b0;
      color_q <= '0;
      fc_q    <= '0;
    end else begin
      if (start_ok) begin
        w_q     <= frame_width;
        h_q     <= frame_height;
        cm_q    <= col_major;
        cont_q  <= continuous;
        color_q <= bg_color;
      end
      if (fire && last_beat) fc_q <= fc_q + 1'b1;
    end
  end

  assign frame_count     = fc_q;
  assign bus.out_valid   = out_valid;
  assign bus.x_out       = x_cnt;
  assign bus.y_out       = y_cnt;
  assign bus.color_out   = color_q;
  assign bus.last        = last_beat;
  assign bus.program_out = out_valid ? PROG_W'(RENDER_PROG) : '0;
endmodule

// File: tb/tb_screen_scan_gen.sv
module tb_screen_scan_gen;
  import screen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0, col_major = 1'b0, continuous = 1'b0;
  logic [10:0] frame_width = '0;
  logic [11:0] frame_height = '0;
  logic [31:0] bg_color = '0;
  logic        busy, done;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;

  screen_scan_gen_if bus();

  screen_scan_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .col_major(col_major), .continuous(continuous),
    .frame_width(frame_width), .frame_height(frame_height), .bg_color(bg_color),
    .bus(bus), .busy(busy), .done(done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle; returns on the negedge where beat 0 should show.
  task automatic kick(input int w, input int h, input bit cm, input bit cont,
                      input logic [31:0] c);
    @(negedge clk);
    frame_width = 11'(w); frame_height = 12'(h);
    col_major = cm; continuous = cont; bg_color = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #11;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if ({bus.x_out, bus.y_out} !== 23'd0) begin n_err++; $display("FAIL reset_xy got=(%0d,%0d) exp=(0,0)", bus.x_out, bus.y_out); end
    n_cmp++; if ({busy, done, bus.last} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {busy, done, bus.last}); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL reset_fc got=%0d exp=0", frame_count); end
    n_cmp++; if ({bus.color_out, bus.program_out} !== 38'd0) begin n_err++; $display("FAIL reset_color got=%h exp=0", bus.color_out); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  // 10x6 column-major single frame: y fastest, beat 6 is (1,0), last on (9,5)
  task automatic test_scan_col;
    kick(10, 6, 1'b1, 1'b0, 32'hA5A5_0001);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [10:0] ex; logic [11:0] ey; logic el;
      if (k > 0) @(negedge clk);
      ex = 11'(k / 6); ey = 12'(k % 6); el = (k == 59);
      n_cmp++;
      if ({bus.out_valid, bus.x_out, bus.y_out, bus.last, done} !== {1'b1, ex, ey, el, 1'b0}) begin
        n_err++;
        $display("FAIL col_beat%0d got v=%b (%0d,%0d) last=%b done=%b exp v=1 (%0d,%0d) last=%b done=0",
                 k, bus.out_valid, bus.x_out, bus.y_out, bus.last, done, ex, ey, el);
      end
    end
    n_cmp++; if (bus.color_out !== 32'hA5A5_0001) begin n_err++; $display("FAIL col_color got=%h exp=a5a50001", bus.color_out); end
    @(negedge clk);
    n_cmp++; if ({done, bus.out_valid} !== 2'b10) begin n_err++; $display("FAIL col_done got done=%b v=%b exp done=1 v=0", done, bus.out_valid); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL col_fc got=%0d exp=1", frame_count); end
    @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL col_idle got done=%b busy=%b exp 00", done, busy); end
    bus.out_ready = 1'b0;
  endtask

  // 4x3 row-major with random stalls: every beat exactly once, held while stalled
  task automatic test_row_stall;
    int k = 0;
    int cyc = 0;
    bit r;
    kick(4, 3, 1'b0, 1'b0, 32'h1234_5678);
    while (k < 12 && cyc < 300) begin
      logic [10:0] ex; logic [11:0] ey; logic el;
      ex = 11'(k % 4); ey = 12'(k / 4); el = (k == 11);
      n_cmp++;
      if ({bus.out_valid, bus.x_out, bus.y_out, bus.last, bus.color_out} !== {1'b1, ex, ey, el, 32'h1234_5678}) begin
        n_err++;
        $display("FAIL row_beat%0d cyc%0d got v=%b (%0d,%0d) last=%b col=%h exp v=1 (%0d,%0d) last=%b",
                 k, cyc, bus.out_valid, bus.x_out, bus.y_out, bus.last, bus.color_out, ex, ey, el);
      end
      r = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.out_ready = r;
      if (r) k++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (k != 12) begin n_err++; $display("FAIL row_timeout got beats=%0d exp=12", k); end
    n_cmp++; if ({done, bus.out_valid} !== 2'b10) begin n_err++; $display("FAIL row_done got done=%b v=%b exp done=1 v=0", done, bus.out_valid); end
    n_cmp++; if (frame_count !== 16'd2) begin n_err++; $display("FAIL row_fc got=%0d exp=2", frame_count); end
    bus.out_ready = 1'b0;
  endtask

  // 2x2 continuous: (1,1)->(0,0) without a bubble, no done
  task automatic test_continuous;
    logic [15:0] fc0;
    fc0 = frame_count;
    kick(2, 2, 1'b0, 1'b1, 32'h0000_00C3);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [10:0] ex; logic [11:0] ey; logic el;
      if (k > 0) @(negedge clk);
      ex = 11'(k % 2); ey = 12'((k % 4) / 2); el = ((k % 4) == 3);
      n_cmp++;
      if ({bus.out_valid, bus.x_out, bus.y_out, bus.last, done} !== {1'b1, ex, ey, el, 1'b0}) begin
        n_err++;
        $display("FAIL cont_beat%0d got v=%b (%0d,%0d) last=%b done=%b exp v=1 (%0d,%0d) last=%b done=0",
                 k, bus.out_valid, bus.x_out, bus.y_out, bus.last, done, ex, ey, el);
      end
      if (k == 8) begin
        n_cmp++; if (frame_count !== fc0 + 16'd2) begin n_err++; $display("FAIL cont_fc got=%0d exp=%0d", frame_count, fc0 + 16'd2); end
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if ({bus.out_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL cont_stop got v/busy/done=%b exp 000", {bus.out_valid, busy, done}); end
    n_cmp++; if (frame_count !== fc0 + 16'd2) begin n_err++; $display("FAIL cont_fc_end got=%0d exp=%0d", frame_count, fc0 + 16'd2); end
  endtask

  // Zero-sized frame requests are ignored
  task automatic test_zero_dim;
    kick(0, 5, 1'b0, 1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({bus.out_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL zeroW_c%0d got v/busy/done=%b exp 000", i, {bus.out_valid, busy, done}); end
      @(negedge clk);
    end
    kick(7, 0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    n_cmp++; if ({bus.out_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL zeroH got v/busy/done=%b exp 000", {bus.out_valid, busy, done}); end
  endtask

  task automatic test_abort;
    logic [15:0] fc0;
    fc0 = frame_count;
    kick(8, 8, 1'b0, 1'b0, 32'h0BAD_F00D);
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.x_out, bus.y_out} !== {1'b1, 11'd4, 12'd2}) begin n_err++; $display("FAIL abort_beat20 got v=%b (%0d,%0d) exp v=1 (4,2)", bus.out_valid, bus.x_out, bus.y_out); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if ({bus.out_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL abort_idle got v/busy/done=%b exp 000", {bus.out_valid, busy, done}); end
    n_cmp++; if (frame_count !== fc0) begin n_err++; $display("FAIL abort_fc got=%0d exp=%0d", frame_count, fc0); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_nodone got=%b exp=0", done); end
    kick(8, 8, 1'b0, 1'b0, 32'h0BAD_F00D);
    n_cmp++; if ({bus.out_valid, bus.x_out, bus.y_out} !== {1'b1, 11'd0, 12'd0}) begin n_err++; $display("FAIL abort_restart got v=%b (%0d,%0d) exp v=1 (0,0)", bus.out_valid, bus.x_out, bus.y_out); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    // abort beats a simultaneous final-pixel transfer
    kick(1, 1, 1'b0, 1'b0, 32'h0000_0001);
    n_cmp++; if ({bus.out_valid, bus.last} !== 2'b11) begin n_err++; $display("FAIL abort_last_beat got v=%b last=%b exp 11", bus.out_valid, bus.last); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if ({bus.out_valid, done, frame_count} !== {2'b00, fc0}) begin n_err++; $display("FAIL abort_prio got v=%b done=%b fc=%0d exp v=0 done=0 fc=%0d", bus.out_valid, done, frame_count, fc0); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_prio_nodone got=%b exp=0", done); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    kick(8, 8, 1'b0, 1'b0, 32'hDEAD_BEEF);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.out_valid, busy, bus.x_out, bus.y_out} !== 25'd0) begin n_err++; $display("FAIL rstmid_xy got v=%b busy=%b (%0d,%0d) exp all 0", bus.out_valid, busy, bus.x_out, bus.y_out); end
    n_cmp++; if ({bus.color_out, frame_count} !== 48'd0) begin n_err++; $display("FAIL rstmid_cfg got col=%h fc=%0d exp 0", bus.color_out, frame_count); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    kick(1, 1, 1'b0, 1'b0, 32'h0000_0777);
    n_cmp++; if ({bus.out_valid, bus.x_out, bus.y_out, bus.last} !== {1'b1, 11'd0, 12'd0, 1'b1}) begin n_err++; $display("FAIL one_beat got v=%b (%0d,%0d) last=%b exp v=1 (0,0) last=1", bus.out_valid, bus.x_out, bus.y_out, bus.last); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++; if ({done, bus.out_valid, frame_count} !== {2'b10, 16'd1}) begin n_err++; $display("FAIL one_done got done=%b v=%b fc=%0d exp done=1 v=0 fc=1", done, bus.out_valid, frame_count); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL one_pulse got=%b exp=0", done); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_scan_col();
    test_row_stall();
    test_continuous();
    test_zero_dim();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
